digit_entry: RTL
================

DIGIT_ENTRY -- requirements
Module: digit_entry

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000, the number of consecutive stable clocks required to accept a key edge (minimum 2).
REQ-002 SHALL have parameter N_DIGITS, default 6, the number of digits per combination sequence (2..8).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port key_n  input  1  raw, asynchronous, bouncing pushbutton (0 = pressed).
REQ-006 SHALL have port sw  input  10  raw, asynchronous slide switches carrying the entered value.
REQ-007 SHALL have port digit  output  4  sw[3:0] captured at accepted press; held until the next accept.
REQ-008 SHALL have port digit_valid  output  1  one-cycle pulse: new digit available for the lock FSM.
REQ-009 SHALL have port digit_err  output  1  high with digit_valid when the captured 10-bit sw > 9; else 0.
REQ-010 SHALL have port entry_idx  output  3  position (0..N_DIGITS-1) of the digit being presented; valid with digit_valid.
REQ-011 SHALL have port seq_done  output  1  one-cycle pulse coincident with digit_valid for position N_DIGITS-1.

Function
REQ-012 SHALL pass key_n and sw through a 2-flop synchronizer each; only the synchronized versions (key_s, sw_s) feed logic.
REQ-013 SHALL implement states IDLE, PRESS_DB, HELD, REL_DB, with a debounce counter cnt of ceil(log2(DEBOUNCE_CYCLES)) bits.
REQ-014 IDLE: key_s=0 -> PRESS_DB, cnt<=0; otherwise stay.
REQ-015 PRESS_DB: key_s=1 -> IDLE, no output (glitch rejected); key_s=0 and cnt<DEBOUNCE_CYCLES-1 -> cnt<=cnt+1; key_s=0 and cnt=DEBOUNCE_CYCLES-1 -> HELD, accept.
REQ-016 Accept: in the same edge, register digit<=sw_s[3:0], digit_err<=(sw_s>9), entry_idx<=current position, digit_valid<=1, seq_done<=(position=N_DIGITS-1).
REQ-017 digit_valid, digit_err and seq_done SHALL be high for exactly one cycle per accept; digit and entry_idx SHALL hold until the next accept.
REQ-018 Latency: a clean press held low SHALL produce digit_valid high in the cycle after rising edge DEBOUNCE_CYCLES+3, counting the first edge that samples key_n=0 as edge 1.
REQ-019 HELD: key_s=1 -> REL_DB, cnt<=0; otherwise stay; no further accepts while held.
REQ-020 REL_DB: key_s=0 -> HELD (release bounce); key_s=1 and cnt<DEBOUNCE_CYCLES-1 -> cnt<=cnt+1; key_s=1 and cnt=DEBOUNCE_CYCLES-1 -> IDLE.
REQ-021 Position counter SHALL increment after each accept and wrap from N_DIGITS-1 to 0; error digits also advance it.
REQ-022 sw changes during PRESS_DB, HELD or REL_DB SHALL NOT alter digit; only the value at the accept edge is captured.
REQ-023 Out-of-range sw (10..1023) SHALL still produce digit_valid, with digit=sw_s[3:0] and digit_err=1.

Reset
REQ-024 rst_n=0 at a rising edge SHALL force state IDLE, cnt=0, position=0, digit=0, entry_idx=0, digit_valid=0, digit_err=0, seq_done=0, synchronizer flops for key to 1 and for sw to 0.
REQ-025 Reset SHALL dominate all transitions; reset during PRESS_DB or HELD SHALL abandon the press with no pulse, and a key still held after reset releases SHALL be debounced as a new press.
REQ-026 Outputs SHALL be registered; no combinational path from key_n or sw to any output.

Verification (DEBOUNCE_CYCLES=4, N_DIGITS=6)
REQ-027 Clean press: sw=7, key_n low for 20 cycles -> single digit_valid in cycle 8 after key_n falls, digit=7, entry_idx=0, digit_err=0.
REQ-028 Bounce: key_n low 2 cycles, high 1, low 20 -> exactly one digit_valid; low pulses shorter than 4 cycles alone -> none.
REQ-029 Full sequence: six presses sw=7,0,3,2,6,2 -> entry_idx 0..5, seq_done only with the digit 2 at idx 5; seventh press -> entry_idx=0.
REQ-030 Error digit: sw=10'h00C pressed -> digit_valid=1, digit_err=1, digit=4'hC, position advances.
REQ-031 Reset mid-press: rst_n low during PRESS_DB for 1 cycle -> no pulse, all outputs 0; key still low -> new accept after a full debounce with entry_idx=0.
REQ-032 sw change while held: capture sw=3, change sw to 9 during HELD -> digit stays 3, no extra pulse.

Source files
------------

// File: rtl/digit_entry.sv
`default_nettype none
// ============================================================================
// digit_entry: debounced pushbutton digit capture with sequence position.
// Revision: 1.0
// ============================================================================
module digit_entry #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int N_DIGITS        = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_n,
  input  logic [9:0] sw,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       digit_err,
  output logic [2:0] entry_idx,
  output logic       seq_done
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]       POS_LAST = 3'(N_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       pos_q;
  logic             key_meta_q, key_s_q;
  logic [9:0]       sw_meta_q, sw_s_q;
  logic [3:0]       digit_q;
  logic [2:0]       idx_q;
  logic             valid_q, err_q, seq_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pos_q      <= '0;
      key_meta_q <= 1'b1;
      key_s_q    <= 1'b1;
      sw_meta_q  <= '0;
      sw_s_q     <= '0;
      digit_q    <= '0;
      idx_q      <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      seq_q      <= 1'b0;
    end else begin
      key_meta_q <= key_n;
      key_s_q    <= key_meta_q;
      sw_meta_q  <= sw;
      sw_s_q     <= sw_meta_q;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      seq_q      <= 1'b0;

      case (state_q)
        IDLE: begin
          if (!key_s_q) begin
            state_q <= PRESS_DB;
            cnt_q   <= '0;
          end
        end
        PRESS_DB: begin
          if (key_s_q) begin
            state_q <= IDLE;
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
          end else begin
            // Press is stable: capture the switches seen on this very edge.
            state_q <= HELD;
            digit_q <= sw_s_q[3:0];
            err_q   <= (sw_s_q > 10'd9);
            idx_q   <= pos_q;
            valid_q <= 1'b1;
            seq_q   <= (pos_q == POS_LAST);
            pos_q   <= (pos_q == POS_LAST) ? 3'd0 : pos_q + 3'd1;
          end
        end
        HELD: begin
          if (key_s_q) begin
            state_q <= REL_DB;
            cnt_q   <= '0;
          end
        end
        REL_DB: begin
          if (!key_s_q) begin
            state_q <= HELD;
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign digit       = digit_q;
  assign digit_valid = valid_q;
  assign digit_err   = err_q;
  assign entry_idx   = idx_q;
  assign seq_done    = seq_q;

endmodule
`default_nettype wire
